// File: rtl/issue_pkg.sv
// issue_pkg: shared types and helpers for the multi-port issue queue.
//   Fixed datapath widths (operand, tag, uop) and the number of snooped CDB
//   lanes live here because the entry and port structs are built from them.
//   rs_entry_t   : one reservation-station entry
//   issue_port_t : payload held in one issue output register
//   cdb_match()  : tag compare against all CDB lanes, lowest lane wins
package issue_pkg;

    localparam int DATA_W    = 32;
    localparam int TAG_W     = 6;
    localparam int CDB_W     = 4;
    localparam int UOP_W     = 16;
    localparam int CDB_IDX_W = (CDB_W > 1) ? $clog2(CDB_W) : 1;

    typedef logic [UOP_W-1:0] uop_t;

    typedef struct packed {
        logic              valid;
        uop_t              uop;
        logic [TAG_W-1:0]  dst;
        logic [DATA_W-1:0] v1;
        logic [TAG_W-1:0]  q1;
        logic              r1;
        logic [DATA_W-1:0] v2;
        logic [TAG_W-1:0]  q2;
        logic              r2;
    } rs_entry_t;

    typedef struct packed {
        uop_t              uop;
        logic [DATA_W-1:0] v1;
        logic [DATA_W-1:0] v2;
        logic [TAG_W-1:0]  dst;
    } issue_port_t;

    typedef struct packed {
        logic                 hit;
        logic [CDB_IDX_W-1:0] lane;
    } cdb_hit_t;

    // Scanning from the top lane down lets the lowest matching lane win.
    function automatic cdb_hit_t cdb_match(
        input logic [TAG_W-1:0]       tag,
        input logic [CDB_W-1:0]       cdb_valid,
        input logic [CDB_W*TAG_W-1:0] cdb_tag
    );
        cdb_hit_t res;
        res = '0;
        for (int c = CDB_W - 1; c >= 0; c--) begin
            if (cdb_valid[c] && (cdb_tag[c*TAG_W +: TAG_W] == tag)) begin
                res.hit  = 1'b1;
                res.lane = CDB_IDX_W'(c);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/issue_queue_multi_age.sv
// age_matrix_select: age ordering and oldest-first grant for the issue queue.
//   older[i][j]=1 means entry i is older than entry j.
//   Ports: clk, rst (async, active-high), flush (clear matrix),
//          alloc (entries written this edge), free (entries released this edge),
//          cand (issue candidates), port_en (port may take a uop),
//          grant (ISSUE_W one-hot vectors of RS_DEPTH bits, port 0 in low bits).
module age_matrix_select #(
    parameter int RS_DEPTH = 16,
    parameter int ISSUE_W  = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic [RS_DEPTH-1:0]         alloc,
    input  logic [RS_DEPTH-1:0]         free,
    input  logic [RS_DEPTH-1:0]         cand,
    input  logic [ISSUE_W-1:0]          port_en,
    output logic [ISSUE_W*RS_DEPTH-1:0] grant
);

    logic [RS_DEPTH-1:0] older [RS_DEPTH];
    logic [RS_DEPTH-1:0] remaining;
    logic [RS_DEPTH-1:0] pick;
    logic                has_older;

    // Allocations in one cycle go to ascending indices in lane order, so
    // among new entries the lower index is the older one; every entry not
    // being allocated is older than every new one. Stale bits of invalid
    // entries are harmless because they are never candidates and are
    // rewritten when the entry is allocated again.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RS_DEPTH; i++) older[i] <= '0;
        end else if (flush) begin
            for (int i = 0; i < RS_DEPTH; i++) older[i] <= '0;
        end else begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                for (int j = 0; j < RS_DEPTH; j++) begin
                    if (alloc[i])
                        older[i][j] <= alloc[j] && (j > i);
                    else if (free[i] || free[j])
                        older[i][j] <= 1'b0;
                    else if (alloc[j])
                        older[i][j] <= 1'b1;
                end
            end
        end
    end

    // Ports take the oldest remaining candidate in index order.
    always_comb begin
        remaining = cand;
        grant     = '0;
        pick      = '0;
        has_older = 1'b0;
        for (int p = 0; p < ISSUE_W; p++) begin
            pick = '0;
            for (int i = 0; i < RS_DEPTH; i++) begin
                has_older = 1'b0;
                for (int j = 0; j < RS_DEPTH; j++)
                    has_older = has_older | (remaining[j] & older[j][i]);
                pick[i] = port_en[p] & remaining[i] & ~has_older;
            end
            grant[p*RS_DEPTH +: RS_DEPTH] = pick;
            remaining = remaining & ~pick;
        end
    end

endmodule

// File: rtl/issue_queue_multi.sv
// issue_queue_multi: out-of-order issue queue (reservation station).
//   Accepts up to DISPATCH_W uops per cycle, wakes operands from CDB_W result
//   buses, and issues up to ISSUE_W ready uops per cycle, oldest first.
//   Ports: clk, rst (async, active-high), flush_i (drop everything),
//          dispatch_* (per-lane uop, dst, operand value/tag/ready; lane k in
//          bits [k*W +: W]), dispatch_ready, cdb_* (result broadcasts),
//          fu_ready / issue_* (registered issue ports), free_count.
//   Handshake: an issue port transfers when issue_valid[p] && fu_ready[p];
//   while fu_ready[p]=0 its payload is held stable. Dispatch is accepted only
//   as a whole group when dispatch_ready=1; otherwise every lane is ignored.
//   DATA_W, TAG_W, CDB_W and the uop width come from issue_pkg.
module issue_queue_multi
    import issue_pkg::*;
#(
    parameter int RS_DEPTH   = 16,
    parameter int DISPATCH_W = 4,
    parameter int ISSUE_W    = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush_i,
    input  logic [DISPATCH_W-1:0]        dispatch_valid,
    input  logic [DISPATCH_W*UOP_W-1:0]  dispatch_uop,
    input  logic [DISPATCH_W*TAG_W-1:0]  dispatch_dst,
    input  logic [DISPATCH_W*DATA_W-1:0] dispatch_v1,
    input  logic [DISPATCH_W*DATA_W-1:0] dispatch_v2,
    input  logic [DISPATCH_W*TAG_W-1:0]  dispatch_q1,
    input  logic [DISPATCH_W*TAG_W-1:0]  dispatch_q2,
    input  logic [DISPATCH_W-1:0]        dispatch_r1,
    input  logic [DISPATCH_W-1:0]        dispatch_r2,
    output logic                         dispatch_ready,
    input  logic [CDB_W-1:0]             cdb_valid,
    input  logic [CDB_W*TAG_W-1:0]       cdb_tag,
    input  logic [CDB_W*DATA_W-1:0]      cdb_val,
    input  logic [ISSUE_W-1:0]           fu_ready,
    output logic [ISSUE_W-1:0]           issue_valid,
    output logic [ISSUE_W*UOP_W-1:0]     issue_uop,
    output logic [ISSUE_W*DATA_W-1:0]    issue_v1,
    output logic [ISSUE_W*DATA_W-1:0]    issue_v2,
    output logic [ISSUE_W*TAG_W-1:0]     issue_dst,
    output logic [$clog2(RS_DEPTH):0]    free_count
);

    localparam int CNT_W  = $clog2(RS_DEPTH) + 1;
    localparam int LANE_W = (DISPATCH_W > 1) ? $clog2(DISPATCH_W) : 1;

    rs_entry_t   ent      [RS_DEPTH];
    rs_entry_t   new_ent  [DISPATCH_W];
    cdb_hit_t    m1       [RS_DEPTH];
    cdb_hit_t    m2       [RS_DEPTH];
    cdb_hit_t    d1, d2;
    logic [DATA_W-1:0] val1 [RS_DEPTH];
    logic [DATA_W-1:0] val2 [RS_DEPTH];
    logic [LANE_W-1:0] alloc_lane [RS_DEPTH];
    logic [RS_DEPTH-1:0] cand, alloc_mask, sel_mask, taken;
    logic                found;
    logic [CNT_W-1:0]    n_disp, n_sel;
    logic [ISSUE_W-1:0]  port_en;
    logic [ISSUE_W*RS_DEPTH-1:0] grant;
    issue_port_t sel_port  [ISSUE_W];
    issue_port_t issue_reg [ISSUE_W];

    assign dispatch_ready = (free_count >= CNT_W'(DISPATCH_W));
    assign port_en        = ~issue_valid | fu_ready;

    // New entries, with operands that the CDB resolves in the dispatch cycle.
    always_comb begin
        d1 = '0;
        d2 = '0;
        for (int k = 0; k < DISPATCH_W; k++) begin
            d1 = cdb_match(dispatch_q1[k*TAG_W +: TAG_W], cdb_valid, cdb_tag);
            d2 = cdb_match(dispatch_q2[k*TAG_W +: TAG_W], cdb_valid, cdb_tag);
            new_ent[k].valid = 1'b1;
            new_ent[k].uop   = dispatch_uop[k*UOP_W +: UOP_W];
            new_ent[k].dst   = dispatch_dst[k*TAG_W +: TAG_W];
            new_ent[k].q1    = dispatch_q1[k*TAG_W +: TAG_W];
            new_ent[k].q2    = dispatch_q2[k*TAG_W +: TAG_W];
            new_ent[k].r1    = dispatch_r1[k] | d1.hit;
            new_ent[k].r2    = dispatch_r2[k] | d2.hit;
            new_ent[k].v1    = (!dispatch_r1[k] && d1.hit) ? cdb_val[d1.lane*DATA_W +: DATA_W]
                                                           : dispatch_v1[k*DATA_W +: DATA_W];
            new_ent[k].v2    = (!dispatch_r2[k] && d2.hit) ? cdb_val[d2.lane*DATA_W +: DATA_W]
                                                           : dispatch_v2[k*DATA_W +: DATA_W];
        end
    end

    // Lane k takes the k-th lowest free entry. Entries selected this cycle
    // are still valid here, so a slot is never freed and refilled in one edge.
    always_comb begin
        alloc_mask = '0;
        n_disp     = '0;
        found      = 1'b0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            taken[i]      = ent[i].valid;
            alloc_lane[i] = '0;
        end
        for (int k = 0; k < DISPATCH_W; k++) begin
            if (dispatch_ready && dispatch_valid[k]) begin
                n_disp = n_disp + CNT_W'(1);
                found  = 1'b0;
                for (int i = 0; i < RS_DEPTH; i++) begin
                    if (!found && !taken[i]) begin
                        found         = 1'b1;
                        taken[i]      = 1'b1;
                        alloc_mask[i] = 1'b1;
                        alloc_lane[i] = LANE_W'(k);
                    end
                end
            end
        end
    end

    // Same-cycle wakeup: a CDB match counts as ready for select and the
    // broadcast value is forwarded straight into the issue register.
    always_comb begin
        for (int i = 0; i < RS_DEPTH; i++) begin
            m1[i]   = cdb_match(ent[i].q1, cdb_valid, cdb_tag);
            m2[i]   = cdb_match(ent[i].q2, cdb_valid, cdb_tag);
            val1[i] = ent[i].r1 ? ent[i].v1 : cdb_val[m1[i].lane*DATA_W +: DATA_W];
            val2[i] = ent[i].r2 ? ent[i].v2 : cdb_val[m2[i].lane*DATA_W +: DATA_W];
            cand[i] = ent[i].valid & (ent[i].r1 | m1[i].hit) & (ent[i].r2 | m2[i].hit);
        end
    end

    age_matrix_select #(
        .RS_DEPTH (RS_DEPTH),
        .ISSUE_W  (ISSUE_W)
    ) u_age (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush_i),
        .alloc   (alloc_mask),
        .free    (sel_mask),
        .cand    (cand),
        .port_en (port_en),
        .grant   (grant)
    );

    always_comb begin
        sel_mask = '0;
        n_sel    = '0;
        for (int p = 0; p < ISSUE_W; p++) begin
            sel_port[p] = '0;
            for (int i = 0; i < RS_DEPTH; i++) begin
                if (grant[p*RS_DEPTH + i]) begin
                    sel_port[p].uop = ent[i].uop;
                    sel_port[p].dst = ent[i].dst;
                    sel_port[p].v1  = val1[i];
                    sel_port[p].v2  = val2[i];
                end
            end
            sel_mask = sel_mask | grant[p*RS_DEPTH +: RS_DEPTH];
            if (|grant[p*RS_DEPTH +: RS_DEPTH]) n_sel = n_sel + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RS_DEPTH; i++) ent[i] <= '0;
            for (int p = 0; p < ISSUE_W; p++) issue_reg[p] <= '0;
            issue_valid <= '0;
            free_count  <= CNT_W'(RS_DEPTH);
        end else if (flush_i) begin
            for (int i = 0; i < RS_DEPTH; i++) ent[i] <= '0;
            for (int p = 0; p < ISSUE_W; p++) issue_reg[p] <= '0;
            issue_valid <= '0;
            free_count  <= CNT_W'(RS_DEPTH);
        end else begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                if (sel_mask[i]) begin
                    ent[i].valid <= 1'b0;
                end else if (alloc_mask[i]) begin
                    ent[i] <= new_ent[alloc_lane[i]];
                end else if (ent[i].valid) begin
                    if (!ent[i].r1 && m1[i].hit) begin
                        ent[i].r1 <= 1'b1;
                        ent[i].v1 <= val1[i];
                    end
                    if (!ent[i].r2 && m2[i].hit) begin
                        ent[i].r2 <= 1'b1;
                        ent[i].v2 <= val2[i];
                    end
                end
            end
            for (int p = 0; p < ISSUE_W; p++) begin
                if (port_en[p]) begin
                    issue_valid[p] <= |grant[p*RS_DEPTH +: RS_DEPTH];
                    if (|grant[p*RS_DEPTH +: RS_DEPTH]) issue_reg[p] <= sel_port[p];
                end
            end
            free_count <= free_count - n_disp + n_sel;
        end
    end

    always_comb begin
        for (int p = 0; p < ISSUE_W; p++) begin
            issue_uop[p*UOP_W +: UOP_W]  = issue_reg[p].uop;
            issue_v1[p*DATA_W +: DATA_W] = issue_reg[p].v1;
            issue_v2[p*DATA_W +: DATA_W] = issue_reg[p].v2;
            issue_dst[p*TAG_W +: TAG_W]  = issue_reg[p].dst;
        end
    end

endmodule

// File: tb/tb_issue_queue_multi.sv
// Directed bench for issue_queue_multi (RS_DEPTH=16, DISPATCH_W=4, ISSUE_W=2).
// Inputs change 1 time unit after each rising edge; outputs are sampled on
// the falling edge. Each uop is tagged 16'hA000 | dst so the uop field can
// be checked alongside the destination tag.
module tb_issue_queue_multi;

    localparam int DW = 4;
    localparam int IW = 2;
    localparam int CW = 4;
    localparam int XW = 32;
    localparam int TW = 6;
    localparam int UW = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic           flush_i;
    logic [DW-1:0]    dispatch_valid;
    logic [DW*UW-1:0] dispatch_uop;
    logic [DW*TW-1:0] dispatch_dst, dispatch_q1, dispatch_q2;
    logic [DW*XW-1:0] dispatch_v1, dispatch_v2;
    logic [DW-1:0]    dispatch_r1, dispatch_r2;
    logic             dispatch_ready;
    logic [CW-1:0]    cdb_valid;
    logic [CW*TW-1:0] cdb_tag;
    logic [CW*XW-1:0] cdb_val;
    logic [IW-1:0]    fu_ready;
    logic [IW-1:0]    issue_valid;
    logic [IW*UW-1:0] issue_uop;
    logic [IW*XW-1:0] issue_v1, issue_v2;
    logic [IW*TW-1:0] issue_dst;
    logic [4:0]       free_count;

    int checks   = 0;
    int failures = 0;

    issue_queue_multi #(.RS_DEPTH(16), .DISPATCH_W(DW), .ISSUE_W(IW)) dut (
        .clk            (clk),
        .rst            (rst),
        .flush_i        (flush_i),
        .dispatch_valid (dispatch_valid),
        .dispatch_uop   (dispatch_uop),
        .dispatch_dst   (dispatch_dst),
        .dispatch_v1    (dispatch_v1),
        .dispatch_v2    (dispatch_v2),
        .dispatch_q1    (dispatch_q1),
        .dispatch_q2    (dispatch_q2),
        .dispatch_r1    (dispatch_r1),
        .dispatch_r2    (dispatch_r2),
        .dispatch_ready (dispatch_ready),
        .cdb_valid      (cdb_valid),
        .cdb_tag        (cdb_tag),
        .cdb_val        (cdb_val),
        .fu_ready       (fu_ready),
        .issue_valid    (issue_valid),
        .issue_uop      (issue_uop),
        .issue_v1       (issue_v1),
        .issue_v2       (issue_v2),
        .issue_dst      (issue_dst),
        .free_count     (free_count)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog observed=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    // Driver tasks
    task automatic clear_in();
        flush_i        = 1'b0;
        dispatch_valid = '0;
        dispatch_uop   = '0;
        dispatch_dst   = '0;
        dispatch_q1    = '0;
        dispatch_q2    = '0;
        dispatch_v1    = '0;
        dispatch_v2    = '0;
        dispatch_r1    = '0;
        dispatch_r2    = '0;
        cdb_valid      = '0;
        cdb_tag        = '0;
        cdb_val        = '0;
    endtask

    task automatic set_lane(input int k, input int dst, input bit r1, input int q1, input int v1,
                            input bit r2, input int q2, input int v2);
        dispatch_valid[k]          = 1'b1;
        dispatch_uop[k*UW +: UW]   = 16'hA000 | UW'(dst);
        dispatch_dst[k*TW +: TW]   = TW'(dst);
        dispatch_r1[k]             = r1;
        dispatch_q1[k*TW +: TW]    = TW'(q1);
        dispatch_v1[k*XW +: XW]    = XW'(v1);
        dispatch_r2[k]             = r2;
        dispatch_q2[k*TW +: TW]    = TW'(q2);
        dispatch_v2[k*XW +: XW]    = XW'(v2);
    endtask

    task automatic set_cdb(input int c, input int tag, input int val);
        cdb_valid[c]          = 1'b1;
        cdb_tag[c*TW +: TW]   = TW'(tag);
        cdb_val[c*XW +: XW]   = XW'(val);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard checks
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_port(input string tag, input int p, input bit ev, input int edst,
                              input int ev1, input int ev2);
        check({tag, "_valid"}, 32'(issue_valid[p]), 32'(ev));
        if (ev) begin
            check({tag, "_dst"}, 32'(issue_dst[p*TW +: TW]), 32'(edst));
            check({tag, "_uop"}, 32'(issue_uop[p*UW +: UW]), 32'h0000A000 | 32'(edst));
            check({tag, "_v1"}, issue_v1[p*XW +: XW], 32'(ev1));
            check({tag, "_v2"}, issue_v2[p*XW +: XW], 32'(ev2));
        end
    endtask

    initial begin
        // Reset
        rst = 1'b1;
        clear_in();
        fu_ready = 2'b11;
        step();
        step();
        rst = 1'b0;
        @(negedge clk);
        check("rst_free", 32'(free_count), 32'd16);
        check("rst_ready", 32'(dispatch_ready), 32'd1);
        check("rst_ivalid", 32'(issue_valid), 32'd0);
        check("rst_dst", 32'(issue_dst), 32'd0);
        check("rst_v1", issue_v1[31:0], 32'd0);
        step();

        // Four ready uops, dst 1..4: ports 0/1 get 1,2 then 3,4
        for (int k = 0; k < 4; k++) set_lane(k, k + 1, 1, 0, 32'h100 + k, 1, 0, 32'h200 + k);
        @(negedge clk);
        check("t1_ready", 32'(dispatch_ready), 32'd1);
        step();
        clear_in();
        @(negedge clk);
        check("t1_c1_ivalid", 32'(issue_valid), 32'd0);
        check("t1_c1_free", 32'(free_count), 32'd12);
        step();
        @(negedge clk);
        check_port("t1_c2_p0", 0, 1, 1, 32'h100, 32'h200);
        check_port("t1_c2_p1", 1, 1, 2, 32'h101, 32'h201);
        check("t1_c2_free", 32'(free_count), 32'd14);
        step();
        @(negedge clk);
        check_port("t1_c3_p0", 0, 1, 3, 32'h102, 32'h202);
        check_port("t1_c3_p1", 1, 1, 4, 32'h103, 32'h203);
        check("t1_c3_free", 32'(free_count), 32'd16);
        step();
        @(negedge clk);
        check("t1_c4_ivalid", 32'(issue_valid), 32'd0);
        step();

        // Resident wakeup: dst 5 waits on tag 9, CDB lane 2 delivers 0xDEAD
        set_lane(0, 5, 0, 9, 0, 1, 0, 32'h55);
        step();
        clear_in();
        @(negedge clk);
        check("t2_wait1", 32'(issue_valid), 32'd0);
        step();
        set_cdb(2, 9, 32'hDEAD);
        @(negedge clk);
        check("t2_wait2", 32'(issue_valid), 32'd0);
        step();
        clear_in();
        @(negedge clk);
        check_port("t2_p0", 0, 1, 5, 32'hDEAD, 32'h55);
        check_port("t2_p1", 1, 0, 0, 0, 0);
        step();
        @(negedge clk);
        check("t2_idle", 32'(issue_valid), 32'd0);
        check("t2_free", 32'(free_count), 32'd16);
        step();

        // Dispatch-time wakeup: q2=7 broadcast in the dispatch cycle
        set_lane(0, 6, 1, 0, 32'h11, 0, 7, 0);
        set_cdb(0, 7, 32'h1234);
        step();
        clear_in();
        @(negedge clk);
        check("t3_c1", 32'(issue_valid), 32'd0);
        step();
        @(negedge clk);
        check_port("t3_p0", 0, 1, 6, 32'h11, 32'h1234);
        step();

        // Age order: young B sits in entry 0, old A in entry 1 wakes with B ready
        set_lane(0, 12, 1, 0, 32'h0C, 1, 0, 32'h0C);
        set_lane(1, 10, 0, 3, 0, 1, 0, 32'h0A);
        step();
        clear_in();
        step();
        @(negedge clk);
        check_port("t4_x", 0, 1, 12, 32'h0C, 32'h0C);
        set_lane(0, 11, 1, 0, 32'h0B, 1, 0, 32'h0B);
        step();
        clear_in();
        set_cdb(1, 3, 32'h333);
        @(negedge clk);
        check("t4_gap", 32'(issue_valid), 32'd0);
        step();
        clear_in();
        @(negedge clk);
        check_port("t4_old_p0", 0, 1, 10, 32'h333, 32'h0A);
        check_port("t4_young_p1", 1, 1, 11, 32'h0B, 32'h0B);
        check("t4_free", 32'(free_count), 32'd16);
        step();

        // Back-pressure on port 0 for three cycles
        for (int k = 0; k < 4; k++) set_lane(k, 20 + k, 1, 0, 20 + k, 1, 0, 32'h100 + 20 + k);
        step();
        clear_in();
        step();
        fu_ready = 2'b10;
        @(negedge clk);
        check_port("t5_c2_p0", 0, 1, 20, 20, 32'h114);
        check_port("t5_c2_p1", 1, 1, 21, 21, 32'h115);
        step();
        @(negedge clk);
        check_port("t5_c3_p0", 0, 1, 20, 20, 32'h114);
        check_port("t5_c3_p1", 1, 1, 22, 22, 32'h116);
        step();
        @(negedge clk);
        check_port("t5_c4_p0", 0, 1, 20, 20, 32'h114);
        check_port("t5_c4_p1", 1, 1, 23, 23, 32'h117);
        check("t5_c4_free", 32'(free_count), 32'd16);
        step();
        fu_ready = 2'b11;
        @(negedge clk);
        check_port("t5_c5_p0", 0, 1, 20, 20, 32'h114);
        check_port("t5_c5_p1", 1, 0, 0, 0, 0);
        step();
        @(negedge clk);
        check("t5_c6_ivalid", 32'(issue_valid), 32'd0);
        step();

        // Fill with blocked uops, reject a dispatch while full, then flush
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 4; k++) set_lane(k, 30 + 4 * c + k, 0, 40, 0, 1, 0, 1);
            @(negedge clk);
            check($sformatf("t6_fill%0d_free", c), 32'(free_count), 32'(16 - 4 * c));
            check($sformatf("t6_fill%0d_ready", c), 32'(dispatch_ready), 32'd1);
            step();
            clear_in();
        end
        set_lane(0, 50, 1, 0, 1, 1, 0, 1);
        @(negedge clk);
        check("t6_full_free", 32'(free_count), 32'd0);
        check("t6_full_ready", 32'(dispatch_ready), 32'd0);
        step();
        clear_in();
        @(negedge clk);
        check("t6_ignored_free", 32'(free_count), 32'd0);
        check("t6_ignored_ivalid", 32'(issue_valid), 32'd0);
        flush_i = 1'b1;
        set_lane(0, 51, 1, 0, 1, 1, 0, 1);
        set_cdb(0, 40, 32'h40);
        step();
        clear_in();
        set_cdb(0, 40, 32'h40);
        @(negedge clk);
        check("t6_flush_free", 32'(free_count), 32'd16);
        check("t6_flush_ready", 32'(dispatch_ready), 32'd1);
        check("t6_flush_ivalid", 32'(issue_valid), 32'd0);
        step();
        clear_in();
        @(negedge clk);
        check("t6_post_ivalid", 32'(issue_valid), 32'd0);
        step();

        // Asynchronous reset mid-operation
        for (int k = 0; k < 4; k++) set_lane(k, 60 + k, 1, 0, 1, 1, 0, 1);
        step();
        clear_in();
        @(negedge clk);
        check("t7_pre_free", 32'(free_count), 32'd12);
        rst = 1'b1;
        #1;
        check("t7_async_free", 32'(free_count), 32'd16);
        check("t7_async_ivalid", 32'(issue_valid), 32'd0);
        step();
        rst = 1'b0;
        step();
        @(negedge clk);
        check("t7_after_ivalid", 32'(issue_valid), 32'd0);
        check("t7_after_free", 32'(free_count), 32'd16);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
